// File: rtl/mtm_alu_deserializer.sv
`default_nettype none
// =============================================================================
// Module   : mtm_alu_deserializer
// Brief    : Serial ALU packet receiver: frames bits into bytes, bytes into
//            operand/CTL packets, and validates CRC4 and opcode.
// Revision : 1.0 - initial release
// =============================================================================
module mtm_alu_deserializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  op_out,
    output logic        data_valid,
    output logic [2:0]  err_flags,
    output logic        err_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        PAYLOAD = 2'd2,
        STOP    = 2'd3
    } state_t;

    localparam logic [2:0] c_ERR_DATA = 3'b100;
    localparam logic [2:0] c_ERR_CRC  = 3'b010;
    localparam logic [2:0] c_ERR_OP   = 3'b001;
    localparam logic [3:0] c_FULL_CNT = 4'd8;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_cmd;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [3:0]  r_byte_cnt;
    logic        r_overflow;
    logic [63:0] r_operands;

    logic        w_frame_done;
    logic        w_frame_err;
    logic        w_data_frame;
    logic        w_ctl_frame;
    logic [2:0]  w_op;
    logic [3:0]  w_crc_rx;
    logic [3:0]  w_crc_calc;
    logic        w_op_ok;
    logic [2:0]  w_flags;

    // Serial CRC4 (x^4+x+1, init 0), MSB of the message shifted in first.
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!sin) w_state_nxt = CMD;
            CMD:     w_state_nxt = PAYLOAD;
            PAYLOAD: if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
            STOP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= 1'b0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                CMD: begin
                    r_cmd     <= sin;
                    r_bit_cnt <= 3'd0;
                end
                PAYLOAD: begin
                    r_shift   <= {r_shift[6:0], sin};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign w_frame_done = (r_state == STOP) && sin;
    assign w_frame_err  = (r_state == STOP) && !sin;
    assign w_data_frame = w_frame_done && !r_cmd;
    assign w_ctl_frame  = w_frame_done && r_cmd;

    assign w_op       = r_shift[6:4];
    assign w_crc_rx   = r_shift[3:0];
    assign w_crc_calc = crc4({r_operands, 1'b1, w_op});
    assign w_op_ok    = (w_op == 3'b000) || (w_op == 3'b001) ||
                        (w_op == 3'b100) || (w_op == 3'b101);

    always_comb begin
        w_flags = 3'b000;
        if ((r_byte_cnt != c_FULL_CNT) || r_overflow) begin
            w_flags = c_ERR_DATA;
        end else if (w_crc_calc != w_crc_rx) begin
            w_flags = c_ERR_CRC;
        end else if (!w_op_ok) begin
            w_flags = c_ERR_OP;
        end
    end

    // Bytes arrive B[31:24] first, so after eight shifts B sits in the top half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= 4'd0;
            r_overflow <= 1'b0;
            r_operands <= 64'h0;
        end else if (w_frame_err || w_ctl_frame) begin
            r_byte_cnt <= 4'd0;
            r_overflow <= 1'b0;
        end else if (w_data_frame) begin
            if (r_byte_cnt == c_FULL_CNT) begin
                r_overflow <= 1'b1;
            end else begin
                r_operands <= {r_operands[55:0], r_shift};
                r_byte_cnt <= r_byte_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out      <= 32'h0;
            b_out      <= 32'h0;
            op_out     <= 3'b000;
            data_valid <= 1'b0;
            err_valid  <= 1'b0;
            err_flags  <= 3'b000;
        end else begin
            data_valid <= 1'b0;
            err_valid  <= 1'b0;
            if (w_ctl_frame) begin
                if (w_flags == 3'b000) begin
                    data_valid <= 1'b1;
                    b_out      <= r_operands[63:32];
                    a_out      <= r_operands[31:0];
                    op_out     <= w_op;
                end else begin
                    err_valid  <= 1'b1;
                    err_flags  <= w_flags;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_deserializer.sv
`default_nettype none
// =============================================================================
// Module   : tb_mtm_alu_deserializer
// Brief    : Directed and random packet stimulus for mtm_alu_deserializer.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mtm_alu_deserializer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        sin   = 1'b1;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [2:0]  op_out;
    logic        data_valid;
    logic [2:0]  err_flags;
    logic        err_valid;

    int checks   = 0;
    int errors   = 0;
    int dv_total = 0;
    int ev_total = 0;
    int exp_dv   = 0;
    int exp_ev   = 0;

    mtm_alu_deserializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .a_out      (a_out),
        .b_out      (b_out),
        .op_out     (op_out),
        .data_valid (data_valid),
        .err_flags  (err_flags),
        .err_valid  (err_valid)
    );

    always #5 clk = ~clk;

    // Pulse counters catch extra, stretched or unexpected pulses anywhere.
    always @(posedge clk) begin
        #1;
        if (data_valid) dv_total++;
        if (err_valid)  ev_total++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Long-division reference: remainder of M(x)*x^4 mod x^4+x+1.
    function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic drive_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_frame_tail(input logic cmd, input logic [7:0] d);
        drive_bit(cmd);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic cmd, input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        drive_bit(cmd);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_frame(1'b0, w[8*k +: 8], 1'b1);
    endtask

    task automatic send_ctl(input logic [2:0] op, input logic [3:0] crc);
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    task automatic send_packet(input logic [31:0] b, input logic [31:0] a,
                               input logic [2:0] op, input logic [3:0] crc_xor);
        send_word(b);
        send_word(a);
        send_ctl(op, crc_ref(b, a, op) ^ crc_xor);
    endtask

    task automatic check_totals(input string tag);
        chk({tag, "_dv_count"}, 64'(dv_total), 64'(exp_dv));
        chk({tag, "_ev_count"}, 64'(ev_total), 64'(exp_ev));
    endtask

    task automatic expect_ok(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] op);
        drive_bit(1'b1);
        exp_dv++;
        chk({tag, "_dv"}, 64'(data_valid), 64'd1);
        chk({tag, "_ev"}, 64'(err_valid), 64'd0);
        chk({tag, "_a"},  64'(a_out), 64'(a));
        chk({tag, "_b"},  64'(b_out), 64'(b));
        chk({tag, "_op"}, 64'(op_out), 64'(op));
        drive_bit(1'b1);
        chk({tag, "_dv_drop"}, 64'(data_valid), 64'd0);
        check_totals(tag);
    endtask

    task automatic expect_err(input string tag, input logic [2:0] flags);
        drive_bit(1'b1);
        exp_ev++;
        chk({tag, "_ev"},    64'(err_valid), 64'd1);
        chk({tag, "_dv"},    64'(data_valid), 64'd0);
        chk({tag, "_flags"}, 64'(err_flags), 64'(flags));
        drive_bit(1'b1);
        chk({tag, "_ev_drop"}, 64'(err_valid), 64'd0);
        check_totals(tag);
    endtask

    initial begin
        logic [31:0] rb;
        logic [31:0] ra;
        logic [2:0]  rop;
        logic [2:0]  ops [4];
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dv",    64'(data_valid), 64'd0);
        chk("rst_ev",    64'(err_valid),  64'd0);
        chk("rst_flags", 64'(err_flags),  64'd0);
        chk("rst_a",     64'(a_out),      64'd0);
        chk("rst_b",     64'(b_out),      64'd0);
        chk("rst_op",    64'(op_out),     64'd0);
        rst_n = 1'b1;
        repeat (2) drive_bit(1'b1);

        // B=2, A=4, OP=AND; CRC hand-derived as 4'b0010
        send_word(32'h0000_0002);
        send_word(32'h0000_0004);
        send_ctl(3'b000, 4'b0010);
        expect_ok("basic", 32'h4, 32'h2, 3'b000);

        // Same packet, corrupted CRC; operands must hold
        send_word(32'h0000_0002);
        send_word(32'h0000_0004);
        send_ctl(3'b000, 4'b0010 ^ 4'hF);
        expect_err("crc_bad", 3'b010);
        chk("hold_a", 64'(a_out), 64'h4);
        chk("hold_b", 64'(b_out), 64'h2);

        // Short packet then full-ones ADD packet
        send_frame(1'b0, 8'h55, 1'b1);
        send_frame(1'b1, 8'h50, 1'b1);
        expect_err("short", 3'b100);
        send_packet(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 4'h0);
        expect_ok("ones_add", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100);

        // Illegal opcode with matching CRC
        send_packet(32'h0000_0003, 32'h0000_0007, 3'b011, 4'h0);
        expect_err("bad_op", 3'b001);

        // Nine DATA frames then CTL
        send_word(32'h1111_2222);
        send_word(32'h3333_4444);
        send_frame(1'b0, 8'hAA, 1'b1);
        send_ctl(3'b000, crc_ref(32'h1111_2222, 32'h3333_4444, 3'b000));
        expect_err("overflow", 3'b100);

        // Framing error on byte 3, then a clean packet
        send_frame(1'b0, 8'h01, 1'b1);
        send_frame(1'b0, 8'h02, 1'b1);
        send_frame(1'b0, 8'h03, 1'b0);
        repeat (3) drive_bit(1'b1);
        check_totals("framing");
        send_packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 4'h0);
        expect_ok("after_framing", 32'h9ABC_DEF0, 32'h1234_5678, 3'b001);

        // Reset during DATA byte 5; start bit sampled on first edge after release
        send_word(32'hDEAD_BEEF);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_a",  64'(a_out),  64'd0);
        chk("midrst_b",  64'(b_out),  64'd0);
        chk("midrst_op", 64'(op_out), 64'd0);
        rst_n = 1'b1;
        sin   = 1'b0;
        send_frame_tail(1'b0, 8'hCA);
        send_frame(1'b0, 8'hFE, 1'b1);
        send_frame(1'b0, 8'hBA, 1'b1);
        send_frame(1'b0, 8'hBE, 1'b1);
        send_word(32'h0BAD_F00D);
        send_ctl(3'b101, crc_ref(32'hCAFE_BABE, 32'h0BAD_F00D, 3'b101));
        expect_ok("after_rst", 32'h0BAD_F00D, 32'hCAFE_BABE, 3'b101);

        // Random valid packets over all legal opcodes
        for (int n = 0; n < 200; n++) begin
            rb  = $urandom;
            ra  = $urandom;
            rop = ops[$urandom_range(0, 3)];
            send_packet(rb, ra, rop, 4'h0);
            expect_ok("random", ra, rb, rop);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
